// File: rtl/sync_fifo_param_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the single-clock FIFO family.
//   FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter.
//   fifo_addr_w(depth)   : pointer width, $clog2(depth).
//   fifo_cnt_w(depth)    : occupancy-count width, one bit wider than a pointer
//                          so that a full FIFO (count == depth) is representable.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Producer/consumer bundle of a sync_fifo_param instance.
//   wr_en, data_in           : write request and data (from the user side)
//   rd_en                    : read/pop request (from the user side)
//   data_out                 : read data (from the FIFO)
//   full, empty              : occupancy status
//   almost_full, almost_empty: threshold status
//   count                    : occupancy, 0..DEPTH
//   overflow, underflow      : one-cycle pulses for rejected write/read
// Modports:
//   master : the user side (drives requests, observes status)
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = fifo_cnt_w(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en,
        output data_in,
        output rd_en,
        input  data_out,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  wr_en,
        input  data_in,
        input  rd_en,
        output data_out,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output count,
        output overflow,
        output underflow
    );

endinterface

// File: rtl/sync_fifo_param_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage, DEPTH x DATA_W, no reset.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, combinational from i_raddr (asynchronous read so the
//             FIFO can present the head word without an extra cycle)
// -----------------------------------------------------------------------------
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// selectable registered or first-word-fall-through read.
//   Parameters: DATA_W, DEPTH (power of two, >= 2), AF_LEVEL, AE_LEVEL, FWFT.
//   clk     : clock, all state updates on the rising edge
//   rst     : synchronous active-high reset
//   fifo_if : slave side of sync_fifo_param_if (requests in, data/status out)
// -----------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = FIFO_STD
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   fifo_if
);

    localparam int ADDR_W = fifo_addr_w(DEPTH);
    localparam int CNT_W  = fifo_cnt_w(DEPTH);

    // Unsupported configurations stop elaboration.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must not exceed DEPTH");
    end
    if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
        $error("sync_fifo_param: FWFT must be FIFO_STD or FIFO_FWFT");
    end

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [DATA_W-1:0] w_rd_data;

    // Status is decoded from the registered count only; the pointers are
    // never compared, so full/empty cannot alias when they are equal.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A read on a full FIFO frees the slot the write needs. Requests are
    // ignored entirely while rst is high so storage is not touched.
    assign w_wr_ok = !rst && fifo_if.wr_en && (!w_full || fifo_if.rd_en);
    assign w_rd_ok = !rst && fifo_if.rd_en && !w_empty;

    always_comb begin
        w_count_next = r_count;
        unique case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointers are ADDR_W bits, so they wrap modulo DEPTH on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count     <= w_count_next;
            r_overflow  <= fifo_if.wr_en && !w_wr_ok;
            r_underflow <= fifo_if.rd_en && w_empty;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (fifo_if.data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word is shown directly; forced to zero while nothing is queued
        // so stale storage never leaks onto the bus.
        assign fifo_if.data_out = w_empty ? '0 : w_rd_data;
    end else begin : g_std
        logic [DATA_W-1:0] r_data_out;

        // The memory read is asynchronous, so the head word sampled here is
        // the pre-edge contents even when a write lands on the same slot.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data_out <= '0;
            end else if (w_rd_ok) begin
                r_data_out <= w_rd_data;
            end
        end

        assign fifo_if.data_out = r_data_out;
    end

    assign fifo_if.full         = w_full;
    assign fifo_if.empty        = w_empty;
    assign fifo_if.almost_full  = (r_count >= CNT_W'(AF_LEVEL));
    assign fifo_if.almost_empty = (r_count <= CNT_W'(AE_LEVEL));
    assign fifo_if.count        = r_count;
    assign fifo_if.overflow     = r_overflow;
    assign fifo_if.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed bench for sync_fifo_param: one registered-read instance (s_if) and
// one first-word-fall-through instance (f_if), sharing clock and reset.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) s_if ();
    sync_fifo_param_if #(.DATA_W(8), .DEPTH(8)) f_if ();

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(FIFO_STD)
    ) u_dut_std (
        .clk     (clk),
        .rst     (rst),
        .fifo_if (s_if)
    );

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(FIFO_FWFT)
    ) u_dut_fwft (
        .clk     (clk),
        .rst     (rst),
        .fifo_if (f_if)
    );

    int   n_total = 0;
    int   n_pass  = 0;
    logic pulse_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
        pulse_seen = pulse_seen | s_if.overflow | s_if.underflow;
    endtask

    task automatic s_push(input logic [7:0] d);
        s_if.wr_en   = 1'b1;
        s_if.data_in = d;
        step();
        s_if.wr_en   = 1'b0;
    endtask

    task automatic s_pop();
        s_if.rd_en = 1'b1;
        step();
        s_if.rd_en = 1'b0;
    endtask

    task automatic s_both(input logic [7:0] d);
        s_if.wr_en   = 1'b1;
        s_if.rd_en   = 1'b1;
        s_if.data_in = d;
        step();
        s_if.wr_en   = 1'b0;
        s_if.rd_en   = 1'b0;
    endtask

    initial begin
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.data_in = '0;
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.data_in = '0;

        // ---- Reset ------------------------------------------------------
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_empty",     s_if.empty,        1);
        chk("rst_count",     s_if.count,        0);
        chk("rst_full",      s_if.full,         0);
        chk("rst_ae",        s_if.almost_empty, 1);
        chk("rst_af",        s_if.almost_full,  0);
        chk("rst_ovf",       s_if.overflow,     0);
        chk("rst_udf",       s_if.underflow,    0);
        chk("rst_dout",      s_if.data_out,     0);
        chk("rst_fwft_dout", f_if.data_out,     0);

        // ---- FWFT: write to empty, then write + pop ----------------------
        f_if.wr_en = 1'b1; f_if.data_in = 8'h5A;
        step();
        f_if.wr_en = 1'b0;
        chk("fwft_5a_dout",  f_if.data_out, 8'h5A);
        chk("fwft_5a_empty", f_if.empty,    0);
        f_if.wr_en = 1'b1; f_if.data_in = 8'h6B;
        step();
        f_if.wr_en = 1'b0;
        chk("fwft_head_kept", f_if.data_out, 8'h5A);
        chk("fwft_count2",    f_if.count,    2);
        f_if.rd_en = 1'b1;
        step();
        f_if.rd_en = 1'b0;
        chk("fwft_pop_6b",    f_if.data_out, 8'h6B);
        chk("fwft_count1",    f_if.count,    1);
        f_if.rd_en = 1'b1;
        step();
        f_if.rd_en = 1'b0;
        chk("fwft_empty_dout", f_if.data_out, 0);
        chk("fwft_empty",      f_if.empty,    1);
        // Simultaneous write and read on empty: word stays, read rejected.
        f_if.wr_en = 1'b1; f_if.rd_en = 1'b1; f_if.data_in = 8'h7C;
        step();
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0;
        chk("fwft_wr_rd_dout", f_if.data_out,  8'h7C);
        chk("fwft_wr_rd_cnt",  f_if.count,     1);
        chk("fwft_wr_rd_udf",  f_if.underflow, 1);

        // ---- Scenario 1: fill --------------------------------------------
        for (int i = 1; i <= 8; i++) begin
            s_push(8'(8'hA0 + i));
            chk($sformatf("fill%0d_count", i), s_if.count,        i);
            chk($sformatf("fill%0d_ae", i),    s_if.almost_empty, (i <= 1));
            chk($sformatf("fill%0d_af", i),    s_if.almost_full,  (i >= 6));
            chk($sformatf("fill%0d_full", i),  s_if.full,         (i == 8));
        end
        s_push(8'h99);
        chk("ovf_pulse", s_if.overflow, 1);
        chk("ovf_count", s_if.count,    8);
        step();
        chk("ovf_clear", s_if.overflow, 0);

        // ---- Scenario 2: drain ------------------------------------------
        for (int i = 1; i <= 8; i++) begin
            s_pop();
            chk($sformatf("drain%0d_dout", i), s_if.data_out, 8'hA0 + i);
        end
        chk("drain_empty", s_if.empty, 1);
        s_pop();
        chk("udf_pulse", s_if.underflow, 1);
        chk("udf_hold",  s_if.data_out,  8'hA8);
        step();
        chk("udf_clear", s_if.underflow, 0);

        // ---- Scenario 3: wrap-around ------------------------------------
        pulse_seen = 1'b0;
        for (int i = 1; i <= 5; i++) s_push(8'(8'hB0 + i));
        for (int i = 1; i <= 5; i++) begin
            s_pop();
            chk($sformatf("wrapB%0d", i), s_if.data_out, 8'hB0 + i);
        end
        for (int i = 1; i <= 8; i++) s_push(8'(8'hC0 + i));
        chk("wrap_full", s_if.full, 1);
        for (int i = 1; i <= 8; i++) begin
            s_pop();
            chk($sformatf("wrapC%0d", i), s_if.data_out, 8'hC0 + i);
        end
        chk("wrap_no_pulse", pulse_seen, 0);

        // ---- Scenario 4: simultaneous read and write --------------------
        for (int i = 1; i <= 8; i++) s_push(8'(8'hF0 + i));
        s_both(8'hD0);
        chk("full_rw_count", s_if.count,    8);
        chk("full_rw_ovf",   s_if.overflow, 0);
        chk("full_rw_dout",  s_if.data_out, 8'hF1);
        for (int i = 2; i <= 8; i++) begin
            s_pop();
            chk($sformatf("tail_F%0d", i), s_if.data_out, 8'hF0 + i);
        end
        s_pop();
        chk("tail_D0", s_if.data_out, 8'hD0);
        s_both(8'hE0);
        chk("empty_rw_udf",   s_if.underflow, 1);
        chk("empty_rw_count", s_if.count,     1);
        chk("empty_rw_hold",  s_if.data_out,  8'hD0);
        s_pop();
        chk("empty_rw_E0", s_if.data_out, 8'hE0);

        // ---- Scenario 6: reset mid-operation ----------------------------
        for (int i = 1; i <= 4; i++) s_push(8'(8'h10 + i));
        chk("pre_rst_count", s_if.count, 4);
        rst = 1'b1; s_if.wr_en = 1'b1; s_if.data_in = 8'h77;
        step();
        rst = 1'b0; s_if.wr_en = 1'b0;
        chk("mid_rst_count", s_if.count,    0);
        chk("mid_rst_empty", s_if.empty,    1);
        chk("mid_rst_dout",  s_if.data_out, 0);
        s_pop();
        chk("mid_rst_udf",   s_if.underflow, 1);
        chk("mid_rst_cnt2",  s_if.count,     0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
